itm_trace_compressor: RTL and testbench

Parametrised instruction-trace compressor for the Instruction Trace Module (ITM). It sits between the core's writeback trace tap and the ITM packetiser, and collapses runs of sequential retired instructions into one message per discontinuity. The block adds configurable widths, count-overflow handling, a valid/ready output with a small message FIFO, and a drop counter for messages lost to back-pressure.

---
 rtl/itm_trace_compressor.sv | 205 ++++++++++++++++++++
 tb/tb_itm_trace_compressor.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/itm_trace_compressor.sv
`default_nettype none
// ============================================================================
// Module      : itm_trace_compressor
// Description : Instruction-trace compressor for the ITM. Collapses runs of
//               sequential retired instructions into a single message per
//               control-flow discontinuity and buffers messages in a small
//               FIFO with a valid/ready output.
//
//   Parameters
//     TS_WIDTH    timestamp width (instantiate with DBG_TIMESTAMP_WIDTH)
//     PC_WIDTH    program counter width
//     CNT_WIDTH   sequential-instruction counter width (MAX = 2^CNT_WIDTH-1)
//     INSN_BYTES  PC increment of a sequential instruction
//     FIFO_DEPTH  output message slots, power of two, >= 2
//
//   Ports
//     clk             clock
//     rst             synchronous active-high reset
//     trace_in_ts     retire timestamp
//     trace_in_pc     retired (writeback) PC
//     trace_in_valid  retire strobe, sampled every cycle, no back-pressure
//     msg_data        {flag, ts, pc, cnt} at the FIFO head
//     msg_valid       FIFO head valid
//     msg_ready       consumer accepts head
//     drop_cnt        saturating count of messages lost on a full FIFO
//
//   Build option
//     DBG_ITM_COUNT_FLUSH_EN : when defined, a sequential sample arriving with
//       the counter at MAX emits a flush message {1, ts, pc, MAX} and restarts
//       the count. When undefined, the counter saturates and the next branch
//       message carries flag=1 to mark the count as a lower bound.
//
// Revision    : 1.0 - initial release
// ============================================================================
module itm_trace_compressor #(
  parameter int TS_WIDTH   = 32,
  parameter int PC_WIDTH   = 32,
  parameter int CNT_WIDTH  = 8,
  parameter int INSN_BYTES = 4,
  parameter int FIFO_DEPTH = 4,
  localparam int MSG_WIDTH = 1 + TS_WIDTH + PC_WIDTH + CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [TS_WIDTH-1:0]  trace_in_ts,
  input  logic [PC_WIDTH-1:0]  trace_in_pc,
  input  logic                 trace_in_valid,
  output logic [MSG_WIDTH-1:0] msg_data,
  output logic                 msg_valid,
  input  logic                 msg_ready,
  output logic [15:0]          drop_cnt
);

  localparam int                   c_addr_w  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CNT_WIDTH-1:0] c_cnt_max = '1;
  localparam logic [PC_WIDTH-1:0]  c_insn    = PC_WIDTH'(INSN_BYTES);
  localparam logic [c_addr_w:0]    c_depth   = (c_addr_w + 1)'(FIFO_DEPTH);

  // --------------------------------------------------------------------------
  // Compression state
  // --------------------------------------------------------------------------
  logic [PC_WIDTH-1:0]  r_prev_pc;
  logic [CNT_WIDTH-1:0] r_cnt;

  logic                 w_accept;
  logic                 w_seq;
  logic                 w_cnt_at_max;
  logic [PC_WIDTH-1:0]  w_pc_step;
  logic                 w_gen;
  logic                 w_flag;
  logic [CNT_WIDTH-1:0] w_cnt_next;
  logic [MSG_WIDTH-1:0] w_msg;

  // PC zero is the tap's idle value and is never treated as a retirement.
  assign w_accept     = trace_in_valid && (trace_in_pc != '0);
  // Step wraps modulo 2^PC_WIDTH; a repeated PC (e.g. a stalled retire
  // replay) also counts as sequential.
  assign w_pc_step    = r_prev_pc + c_insn;
  assign w_seq        = (trace_in_pc == w_pc_step) || (trace_in_pc == r_prev_pc);
  assign w_cnt_at_max = (r_cnt == c_cnt_max);

`ifdef DBG_ITM_COUNT_FLUSH_EN
  always_comb begin
    w_gen      = 1'b0;
    w_flag     = 1'b0;
    w_cnt_next = r_cnt;
    if (w_accept) begin
      if (!w_seq) begin
        w_gen      = 1'b1;
        w_cnt_next = '0;
      end else if (w_cnt_at_max) begin
        // Flush: decoder treats this as a branch to pc after MAX sequential
        // instructions, so the count never loses precision.
        w_gen      = 1'b1;
        w_flag     = 1'b1;
        w_cnt_next = '0;
      end else begin
        w_cnt_next = r_cnt + 1'b1;
      end
    end
  end
`else
  logic r_sat;
  logic w_sat_next;

  always_comb begin
    w_gen      = 1'b0;
    w_flag     = r_sat;
    w_cnt_next = r_cnt;
    w_sat_next = r_sat;
    if (w_accept) begin
      if (!w_seq) begin
        w_gen      = 1'b1;
        w_cnt_next = '0;
        w_sat_next = 1'b0;
      end else if (w_cnt_at_max) begin
        // Count is pinned at MAX; remember that it is now only a lower bound.
        w_sat_next = 1'b1;
      end else begin
        w_cnt_next = r_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sat <= 1'b0;
    end else begin
      r_sat <= w_sat_next;
    end
  end
`endif

  // The message always carries the count accumulated before this sample; in
  // the flush case r_cnt is already MAX.
  assign w_msg = {w_flag, trace_in_ts, trace_in_pc, r_cnt};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev_pc <= '0;
      r_cnt     <= '0;
    end else begin
      r_cnt <= w_cnt_next;
      if (w_accept) begin
        r_prev_pc <= trace_in_pc;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Message FIFO
  // --------------------------------------------------------------------------
  logic [MSG_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [c_addr_w-1:0]  r_rd_ptr;
  logic [c_addr_w-1:0]  r_wr_ptr;
  logic [c_addr_w:0]    r_count;
  logic [15:0]          r_drop;

  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;

  assign msg_valid = (r_count != '0);
  // Storage is cleared on reset, so the head reads zero until the first push.
  assign msg_data  = r_mem[r_rd_ptr];
  assign drop_cnt  = r_drop;

  assign w_full = (r_count == c_depth);
  assign w_pop  = msg_valid && msg_ready;
  // A pop frees a slot in the same cycle, so a push into a full FIFO survives
  // when the head is being consumed.
  assign w_push = w_gen && (!w_full || w_pop);
  assign w_drop = w_gen && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_drop   <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_msg;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_drop && (r_drop != 16'hFFFF)) begin
        r_drop <= r_drop + 16'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_itm_trace_compressor.sv
`default_nettype none
// ============================================================================
// Module      : tb_itm_trace_compressor
// Description : Self-checking bench for itm_trace_compressor. A queue-based
//               reference model predicts the message stream and drop count;
//               a monitor compares DUT outputs against it on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_itm_trace_compressor;

  localparam int TSW   = 16;
  localparam int PCW   = 16;
  localparam int CNTW  = 2;
  localparam int INSN  = 4;
  localparam int DEPTH = 4;
  localparam int MSGW  = 1 + TSW + PCW + CNTW;
  localparam int MAXC  = (1 << CNTW) - 1;

  logic            clk;
  logic            rst;
  logic [TSW-1:0]  trace_in_ts;
  logic [PCW-1:0]  trace_in_pc;
  logic            trace_in_valid;
  logic [MSGW-1:0] msg_data;
  logic            msg_valid;
  logic            msg_ready;
  logic [15:0]     drop_cnt;

  itm_trace_compressor #(
    .TS_WIDTH   (TSW),
    .PC_WIDTH   (PCW),
    .CNT_WIDTH  (CNTW),
    .INSN_BYTES (INSN),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .trace_in_ts    (trace_in_ts),
    .trace_in_pc    (trace_in_pc),
    .trace_in_valid (trace_in_valid),
    .msg_data       (msg_data),
    .msg_valid      (msg_valid),
    .msg_ready      (msg_ready),
    .drop_cnt       (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: expected FIFO contents as a queue plus an occupancy
  // count, updated on each rising edge from the stable inputs.
  // --------------------------------------------------------------------------
  longint exp_q[$];
  int     occ      = 0;
  int     m_drop   = 0;
  int     m_prev   = 0;
  int     m_cnt    = 0;
  bit     m_sat    = 0;
  bit     pristine = 1;

  function automatic longint pack(input int flag, input int ts, input int pc, input int cnt);
    return (longint'(flag) << (TSW + PCW + CNTW)) | (longint'(ts) << (PCW + CNTW)) |
           (longint'(pc) << CNTW) | longint'(cnt);
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        exp_q.delete();
        occ      = 0;
        m_drop   = 0;
        m_prev   = 0;
        m_cnt    = 0;
        m_sat    = 0;
        pristine = 1;
      end else begin
        bit     pop;
        bit     gen;
        bit     seq;
        longint msg;
        int     pc;
        int     ts;
        pc  = int'(trace_in_pc);
        ts  = int'(trace_in_ts);
        pop = msg_ready && (occ > 0);
        gen = 0;
        msg = 0;
        if (trace_in_valid && pc != 0) begin
          seq = (pc == ((m_prev + INSN) % (1 << PCW))) || (pc == m_prev);
          if (seq) begin
`ifdef DBG_ITM_COUNT_FLUSH_EN
            if (m_cnt == MAXC) begin
              gen   = 1;
              msg   = pack(1, ts, pc, MAXC);
              m_cnt = 0;
            end else begin
              m_cnt++;
            end
`else
            if (m_cnt == MAXC) m_sat = 1;
            else m_cnt++;
`endif
          end else begin
            gen   = 1;
            msg   = pack(int'(m_sat), ts, pc, m_cnt);
            m_cnt = 0;
            m_sat = 0;
          end
          m_prev = pc;
        end
        if (gen) begin
          if (occ < DEPTH || pop) begin
            exp_q.push_back(msg);
            occ++;
            pristine = 0;
          end else if (m_drop < 65535) begin
            m_drop++;
          end
        end
        if (pop) occ--;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Monitor: compares the presented head against the scoreboard and retires
  // it when the handshake completes on the next rising edge.
  // --------------------------------------------------------------------------
  initial begin
    forever begin
      @(negedge clk);
      chk("msg_valid", 64'(msg_valid), 64'(occ != 0));
      chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
      if (msg_valid && exp_q.size() > 0) begin
        chk("msg_data", 64'(msg_data), 64'(exp_q[0]));
        if (msg_ready) void'(exp_q.pop_front());
      end else if (pristine && !msg_valid) begin
        chk("msg_data_idle", 64'(msg_data), 64'd0);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  int ts_ctr  = 1;
  int drv_pc  = 0;

  task automatic cyc(input logic v, input int pc, input logic rdy);
    trace_in_valid = v;
    trace_in_pc    = pc[PCW-1:0];
    trace_in_ts    = ts_ctr[TSW-1:0];
    msg_ready      = rdy;
    if (v && pc != 0) drv_pc = pc;
    @(posedge clk);
    #1;
    ts_ctr++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(1'b0, 0, 1'b1);
    rst = 1'b0;
  endtask

  initial begin
    rst            = 1'b1;
    trace_in_valid = 1'b0;
    trace_in_pc    = '0;
    trace_in_ts    = '0;
    msg_ready      = 1'b1;
    cyc(1'b0, 0, 1'b1);
    cyc(1'b0, 0, 1'b1);
    rst = 1'b0;
    cyc(1'b0, 0, 1'b1);

    // Sequential run then a branch.
    cyc(1'b1, 'h100, 1'b1);
    cyc(1'b1, 'h104, 1'b1);
    cyc(1'b1, 'h108, 1'b1);
    cyc(1'b1, 'h200, 1'b1);
    cyc(1'b0, 0, 1'b1);

    // Zero PC ignored; repeated PCs count as sequential.
    cyc(1'b1, 0, 1'b1);
    cyc(1'b1, 'h300, 1'b1);
    cyc(1'b1, 0, 1'b1);
    cyc(1'b1, 'h300, 1'b1);
    cyc(1'b1, 'h300, 1'b1);
    cyc(1'b1, 'h500, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 0, 1'b1);

    // Overflow: six branches with the consumer stalled.
    for (int i = 0; i < 6; i++) cyc(1'b1, 'h2000 + i * 'h1000, 1'b0);
    chk("drop_after_overflow", 64'(drop_cnt), 64'd2);
    // Full FIFO, pop and push in the same cycle.
    cyc(1'b1, 'h9000, 1'b1);
    chk("drop_full_with_pop", 64'(drop_cnt), 64'd2);
    for (int i = 0; i < 6; i++) cyc(1'b0, 0, 1'b1);

    // Counter reaching MAX with five sequential samples.
    cyc(1'b1, 'h1000, 1'b1);
    for (int i = 1; i <= 5; i++) cyc(1'b1, 'h1000 + i * INSN, 1'b1);
    cyc(1'b1, 'hA000, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 0, 1'b1);

    // Reset while three messages are buffered.
    for (int i = 0; i < 3; i++) cyc(1'b1, 'h4000 + i * 'h100, 1'b0);
    rst = 1'b1;
    cyc(1'b1, 'h7000, 1'b0);
    rst = 1'b0;
    chk("valid_after_reset", 64'(msg_valid), 64'd0);
    chk("drop_after_reset", 64'(drop_cnt), 64'd0);
    cyc(1'b1, 'h4400, 1'b1);
    cyc(1'b0, 0, 1'b1);

    // Randomised traffic including PC wrap-around, zeros and stalls.
    for (int i = 0; i < 3000; i++) begin
      int  sel;
      int  pc;
      logic rdy;
      logic v;
      sel = int'($urandom_range(0, 9));
      case (sel)
        0, 1, 2, 3: pc = (drv_pc + INSN) % (1 << PCW);
        4:          pc = drv_pc;
        5:          pc = 0;
        6:          pc = 'hFFF0 + int'($urandom_range(0, 15));
        default:    pc = int'($urandom_range(1, 'hFFFF));
      endcase
      v   = ($urandom_range(0, 4) != 0);
      rdy = ((i / 40) % 3 == 1) ? 1'b0 : ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 299) == 0) do_reset();
      else cyc(v, pc, rdy);
    end

    // Drain with a bounded wait.
    begin
      int budget;
      budget = 0;
      while (occ != 0 && budget < 20) begin
        cyc(1'b0, 0, 1'b1);
        budget++;
      end
      chk("drain_complete", 64'(occ), 64'd0);
    end
    cyc(1'b0, 0, 1'b1);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
